return_sequencer: RTL
=====================

# return_sequencer

Controls change return for the vending machine. It runs the inactivity wait timer. When the timer expires or the return button is pressed, it dispenses the outstanding balance one coin per cycle, largest coin first. It sits beside the current-total datapath. It reads the datapath's balance, and its one-hot `o_return_coin` feeds back into the datapath's return-total accumulation.

## Interface
Parameters:
- `kNumCoins`, 3: number of coin types.
- `kTotalBits`, 31: width of money quantities.
- `kWaitTime`, 100: inactivity timeout in cycles.
- `kCoin0`, `kCoin1`, `kCoin2`, 100 / 500 / 1000: coin values. Index 2 is the largest.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `i_activity`, in, 1: the datapath accepted a coin or dispensed an item this cycle.
- `i_trigger_return`, in, 1: return button, level-sampled each cycle.
- `i_balance`, in, `kTotalBits`: current balance from the datapath, unsigned.
- `o_return_coin`, out, `kNumCoins`: one-hot coin being returned this cycle.
- `o_returning`, out, 1: high in RETURN. The datapath must refuse coins and selections while it is high.
- `o_return_done`, out, 1: one-cycle pulse marking the end of a return sequence.
- `o_wait_time`, out, 32: remaining wait cycles.

## Operation
- States: IDLE, WAIT, RETURN, DONE. Encodings are 2 bits.
- IDLE:
  - `i_trigger_return` → RETURN.
  - `i_activity` → WAIT, with the timer loaded to `kWaitTime`.
- WAIT:
  - The timer decrements by 1 per cycle.
  - `i_activity` reloads the timer to `kWaitTime`.
  - `i_trigger_return` → RETURN.
  - Timer reaching 0 → RETURN if `i_balance` > 0, otherwise IDLE.
- On entry to RETURN, `i_balance` is snapshotted into the internal `remaining` register (`kTotalBits`). Each cycle in RETURN:
  - Pick the largest coin c with value ≤ `remaining`.
  - Drive `o_return_coin[c]`=1 and update `remaining -= value(c)`.
  - If no coin fits (`remaining` < `kCoin0`, including 0), drive `o_return_coin`=0 and go to DONE.
- DONE: `o_return_done`=1 for exactly one cycle, timer cleared to 0, then → IDLE.
- Width and arithmetic rules:
  - All comparisons are unsigned.
  - Subtraction cannot underflow, because a coin is only chosen when its value ≤ `remaining`.
  - A residue below `kCoin0` is abandoned silently.
- Priority and boundary rules:
  - Simultaneous trigger and activity: trigger wins.
  - Activity in the same cycle the timer hits 0: activity wins, and the timer reloads.
  - Trigger and activity are ignored in RETURN and DONE.
  - Trigger with balance 0 goes through RETURN for zero coin cycles, then DONE.
  - `i_balance` changes during RETURN are ignored; only the snapshot is used.

## Timing
- Reset values: state IDLE; `o_return_coin`=0; `o_returning`=0; `o_return_done`=0; `o_wait_time`=0; `remaining`=0.
- Reset asserted mid-return aborts immediately at the next edge. No further coins are issued.
- Outputs are Moore outputs, derived from registered state and `remaining` only.
- Trigger sampled at edge N:
  - `o_returning` goes high and the first coin appears in cycle N+1.
  - k coins occupy cycles N+1..N+k.
  - Cycle N+k+1 is still in RETURN with `o_return_coin`=0.
  - `o_return_done` pulses at N+k+2.
  - The block is back in IDLE at N+k+3.
- Activity sampled at edge N: `o_wait_time`=`kWaitTime` in cycle N+1, then decrements by 1 each cycle. RETURN is entered at the cycle after `o_wait_time` reads 0.
- Throughput: one coin per cycle, no bubbles between coins.

## Structure
- `kNumCoins`, `kTotalBits`, `kWaitTime` and the coin values belong in `vending_machine_def.v`.
- The four state encodings belong in a shared `return_state_def.v`.
- One combinational sub-module, `coin_picker`:
  - Input: `remaining`.
  - Outputs: the one-hot coin and its value, with a `none` flag.
  - It is instantiated once inside `return_sequencer`.
- The FSM, wait timer and `remaining` register stay in the top module.

## Test plan
- Reset, then idle for 10 cycles → all outputs 0, state IDLE.
- Activity at cycle 5 with `i_balance`=1700 and no further input:
  - `o_wait_time`=100 at cycle 6, counting down to 0.
  - Coins then return in order 1000, 500, 100, 100 on consecutive cycles.
  - One `o_return_done` pulse follows.
- Balance 600 and trigger pulse:
  - Coins 500 in cycle N+1 and 100 in cycle N+2.
  - Done pulse at N+4.
  - Coin and activity inputs during RETURN are ignored.
- Activity repeated every 50 cycles with `kWaitTime`=100 → no return is ever triggered. Timer reloads at activity-plus-1.
- Trigger with balance 0 → no coin cycles, `o_return_done` at N+2. Trigger and activity in the same cycle → RETURN is entered.
- Reset asserted after the second coin of a 3-coin return → `o_return_coin`=0 from the next cycle, no done pulse, state IDLE.

Source files
------------

// File: rtl/return_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// return_sequencer_pkg
// Shared definitions for the vending-machine change-return logic:
//   - machine-wide defaults (coin count, money width, inactivity timeout,
//     coin values, with index 2 being the largest coin)
//   - the 2-bit state encoding of the return sequencer FSM
// -----------------------------------------------------------------------------
package return_sequencer_pkg;

    localparam int K_NUM_COINS  = 3;
    localparam int K_TOTAL_BITS = 31;
    localparam int K_WAIT_TIME  = 100;
    localparam int K_COIN0      = 100;
    localparam int K_COIN1      = 500;
    localparam int K_COIN2      = 1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RETURN = 2'd2,
        ST_DONE   = 2'd3
    } ret_state_t;

endpackage

// File: rtl/return_sequencer_coin_picker.sv
// -----------------------------------------------------------------------------
// coin_picker
// Combinational selection of the largest coin whose value fits in the
// remaining amount.
//   remaining   in  : amount still to be returned (unsigned)
//   coin_onehot out : one-hot index of the chosen coin (0 when none fits)
//   coin_value  out : value of the chosen coin (0 when none fits)
//   none        out : no coin fits (remaining below the smallest coin)
// Coin values must be ascending with index (kCoin0 < kCoin1 < kCoin2).
// -----------------------------------------------------------------------------
module coin_picker
    import return_sequencer_pkg::*;
#(
    parameter int kNumCoins  = K_NUM_COINS,
    parameter int kTotalBits = K_TOTAL_BITS,
    parameter int kCoin0     = K_COIN0,
    parameter int kCoin1     = K_COIN1,
    parameter int kCoin2     = K_COIN2
) (
    input  logic [kTotalBits-1:0] remaining,
    output logic [kNumCoins-1:0]  coin_onehot,
    output logic [kTotalBits-1:0] coin_value,
    output logic                  none
);

    // Indices beyond the defined coins get an all-ones value so they never fit.
    function automatic logic [kTotalBits-1:0] value_of(input int idx);
        case (idx)
            0:       return kTotalBits'(kCoin0);
            1:       return kTotalBits'(kCoin1);
            2:       return kTotalBits'(kCoin2);
            default: return '1;
        endcase
    endfunction

    // Scan smallest to largest; the last coin that fits is the largest one.
    always_comb begin
        coin_onehot = '0;
        coin_value  = '0;
        none        = 1'b1;
        for (int i = 0; i < kNumCoins; i++) begin
            if (value_of(i) <= remaining) begin
                coin_onehot    = '0;
                coin_onehot[i] = 1'b1;
                coin_value     = value_of(i);
                none           = 1'b0;
            end
        end
    end

endmodule

// File: rtl/return_sequencer.sv
// -----------------------------------------------------------------------------
// return_sequencer
// Change-return controller for the vending machine. Runs the inactivity
// timer and, on timeout (with a non-zero balance) or the return button,
// dispenses a snapshot of the balance one coin per cycle, largest first.
//   clk              in  : clock
//   reset            in  : synchronous active-high reset
//   i_activity       in  : datapath accepted a coin / vended an item
//   i_trigger_return in  : return button (level sampled)
//   i_balance        in  : current balance from the datapath (unsigned)
//   o_return_coin    out : one-hot coin returned this cycle
//   o_returning      out : high while in RETURN (datapath must lock out)
//   o_return_done    out : one-cycle pulse ending a return sequence
//   o_wait_time      out : remaining inactivity cycles
// All outputs are Moore outputs of the state and remaining registers.
// -----------------------------------------------------------------------------
module return_sequencer
    import return_sequencer_pkg::*;
#(
    parameter int kNumCoins  = K_NUM_COINS,
    parameter int kTotalBits = K_TOTAL_BITS,
    parameter int kWaitTime  = K_WAIT_TIME,
    parameter int kCoin0     = K_COIN0,
    parameter int kCoin1     = K_COIN1,
    parameter int kCoin2     = K_COIN2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_activity,
    input  logic                  i_trigger_return,
    input  logic [kTotalBits-1:0] i_balance,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic                  o_returning,
    output logic                  o_return_done,
    output logic [31:0]           o_wait_time
);

    ret_state_t            state;
    ret_state_t            state_next;
    logic [31:0]           wait_timer;
    logic [kTotalBits-1:0] remaining;

    logic [kNumCoins-1:0]  pick_onehot;
    logic [kTotalBits-1:0] pick_value;
    logic                  pick_none;

    coin_picker #(
        .kNumCoins  (kNumCoins),
        .kTotalBits (kTotalBits),
        .kCoin0     (kCoin0),
        .kCoin1     (kCoin1),
        .kCoin2     (kCoin2)
    ) u_coin_picker (
        .remaining   (remaining),
        .coin_onehot (pick_onehot),
        .coin_value  (pick_value),
        .none        (pick_none)
    );

    // Trigger beats activity; activity beats a timer expiring in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_trigger_return)  state_next = ST_RETURN;
                else if (i_activity)   state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_trigger_return)  state_next = ST_RETURN;
                else if (i_activity)   state_next = ST_WAIT;
                else if (wait_timer == 32'd0)
                    state_next = (i_balance != '0) ? ST_RETURN : ST_IDLE;
            end
            ST_RETURN: begin
                if (pick_none)         state_next = ST_DONE;
            end
            ST_DONE:                   state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_timer <= 32'd0;
            remaining  <= '0;
        end else begin
            state <= state_next;

            case (state)
                ST_IDLE: begin
                    if (!i_trigger_return && i_activity)
                        wait_timer <= 32'(kWaitTime);
                end
                ST_WAIT: begin
                    if (!i_trigger_return) begin
                        if (i_activity)
                            wait_timer <= 32'(kWaitTime);
                        else if (wait_timer != 32'd0)
                            wait_timer <= wait_timer - 32'd1;
                    end
                end
                ST_DONE:   wait_timer <= 32'd0;
                default:   wait_timer <= wait_timer;
            endcase

            // Balance is captured once on entry; later balance changes are ignored.
            if (state != ST_RETURN && state_next == ST_RETURN)
                remaining <= i_balance;
            else if (state == ST_RETURN && !pick_none)
                remaining <= remaining - pick_value;
        end
    end

    assign o_returning   = (state == ST_RETURN);
    assign o_return_coin = (state == ST_RETURN) ? pick_onehot : '0;
    assign o_return_done = (state == ST_DONE);
    assign o_wait_time   = wait_timer;

endmodule
